// File: rtl/twiddle_mult_4_if.sv
// Sample/coefficient in, scaled product out, plus the shared pipeline enable.
// Shared by the twiddle multiplier and its producer/consumer.
interface twiddle_mult_4_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8
);
    logic              en;
    logic              in_valid;
    logic [DATA_W-1:0] sample;
    logic [COEF_W-1:0] coef;
    logic              out_valid;
    logic [DATA_W-1:0] product;
    logic              ovf;

    modport master (
        output en, in_valid, sample, coef,
        input  out_valid, product, ovf
    );

    modport slave (
        input  en, in_valid, sample, coef,
        output out_valid, product, ovf
    );
endinterface

// File: rtl/twiddle_mult_4.sv
// Pipelined signed sample x Q1.7 twiddle multiplier: sign-magnitude shift-add, one coef bit per stage.
// Define TWIDDLE_ROUND_EN for round-half-away-from-zero scaling; otherwise the magnitude is truncated.
module twiddle_mult_4 #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int FRAC_W = 7
) (
    input logic              clk,
    input logic              rst_n,
    twiddle_mult_4_if.slave  bus
);
    localparam int ACC_W = DATA_W + COEF_W;
    localparam int MAG_W = ACC_W - FRAC_W;
    localparam logic [MAG_W-1:0]  POS_LIM  = MAG_W'((1 << (DATA_W - 1)) - 1);
    localparam logic [MAG_W-1:0]  NEG_LIM  = MAG_W'(1 << (DATA_W - 1));
    localparam logic [DATA_W-1:0] SAT_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef TWIDDLE_ROUND_EN
    localparam logic [ACC_W-1:0]  HALF_LSB = ACC_W'(1 << (FRAC_W - 1));
`endif

    // Stage 0 captures the operands; stages 1..COEF_W each consume one coefficient bit.
    logic [ACC_W-1:0]  acc_q  [0:COEF_W];
    logic              sign_q [0:COEF_W];
    logic              vld_q  [0:COEF_W];
    logic [ACC_W-1:0]  ms_q   [0:COEF_W-1];
    logic [COEF_W-1:0] mc_q   [0:COEF_W-1];

    logic [DATA_W-1:0] mag_s;
    logic [COEF_W-1:0] mag_c;
    logic [MAG_W-1:0]  mag_r;
    logic [DATA_W-1:0] prod_c;
    logic              ovf_c;

    always_comb begin
        mag_s = bus.sample[DATA_W-1] ? DATA_W'(-bus.sample) : bus.sample;
        mag_c = bus.coef[COEF_W-1]   ? COEF_W'(-bus.coef)   : bus.coef;
    end

    always_comb begin
`ifdef TWIDDLE_ROUND_EN
        mag_r = MAG_W'((acc_q[COEF_W] + HALF_LSB) >> FRAC_W);
`else
        mag_r = acc_q[COEF_W][ACC_W-1:FRAC_W];
`endif
        prod_c = '0;
        ovf_c  = 1'b0;
        if (!sign_q[COEF_W]) begin
            if (mag_r > POS_LIM) begin
                prod_c = SAT_POS;
                ovf_c  = 1'b1;
            end else begin
                prod_c = mag_r[DATA_W-1:0];
            end
        end else begin
            // Negating a zero magnitude still yields +0, and NEG_LIM itself maps onto the most negative code.
            if (mag_r > NEG_LIM) begin
                prod_c = SAT_NEG;
                ovf_c  = 1'b1;
            end else begin
                prod_c = DATA_W'(-mag_r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= COEF_W; i++) begin
                acc_q[i]  <= '0;
                sign_q[i] <= 1'b0;
                vld_q[i]  <= 1'b0;
            end
            for (int i = 0; i < COEF_W; i++) begin
                ms_q[i] <= '0;
                mc_q[i] <= '0;
            end
            bus.out_valid <= 1'b0;
            bus.product   <= '0;
            bus.ovf       <= 1'b0;
        end else if (bus.en) begin
            vld_q[0]  <= bus.in_valid;
            sign_q[0] <= bus.sample[DATA_W-1] ^ bus.coef[COEF_W-1];
            acc_q[0]  <= '0;
            ms_q[0]   <= ACC_W'(mag_s);
            mc_q[0]   <= mag_c;
            for (int i = 1; i <= COEF_W; i++) begin
                vld_q[i]  <= vld_q[i-1];
                sign_q[i] <= sign_q[i-1];
                acc_q[i]  <= mc_q[i-1][0] ? acc_q[i-1] + ms_q[i-1] : acc_q[i-1];
            end
            for (int i = 1; i < COEF_W; i++) begin
                ms_q[i] <= ms_q[i-1] << 1;
                mc_q[i] <= mc_q[i-1] >> 1;
            end
            // A bubble leaves the last product on the bus but clears the flags.
            if (vld_q[COEF_W]) begin
                bus.out_valid <= 1'b1;
                bus.product   <= prod_c;
                bus.ovf       <= ovf_c;
            end else begin
                bus.out_valid <= 1'b0;
                bus.ovf       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_twiddle_mult_4.sv
// Self-checking bench for twiddle_mult_4: directed cases, stall, mid-stream reset and random traffic.
// Expected values come from integer arithmetic plus a due-edge scoreboard; honours TWIDDLE_ROUND_EN.
module tb_twiddle_mult_4;
    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst_n;

    twiddle_mult_4_if #(.DATA_W(16), .COEF_W(8)) bus ();

    twiddle_mult_4 #(.DATA_W(16), .COEF_W(8), .FRAC_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] prod;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          en_edges = 0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_prod = '0;
    logic        exp_ovf = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    function automatic void ref_mult(input logic signed [15:0] s, input logic signed [7:0] c,
                                     output logic [15:0] prod, output logic ovf);
        int p;
        int mag;
        bit neg;
        p   = int'(s) * int'(c);
        neg = (p < 0);
        mag = neg ? -p : p;
`ifdef TWIDDLE_ROUND_EN
        mag = (mag + 64) / 128;
`else
        mag = mag / 128;
`endif
        ovf = 1'b0;
        if (!neg && mag > 32767) begin
            prod = 16'h7FFF;
            ovf  = 1'b1;
        end else if (neg && mag > 32768) begin
            prod = 16'h8000;
            ovf  = 1'b1;
        end else begin
            prod = neg ? 16'(-mag) : 16'(mag);
        end
    endfunction

    task automatic check_one(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_output();
        check_one("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check_one("product",   32'(bus.product),   32'(exp_prod));
        check_one("ovf",       32'(bus.ovf),       32'(exp_ovf));
    endtask

    // One clock: drive, advance the scoreboard for that edge, then compare just after the edge.
    task automatic apply_stimulus(input logic r, input logic e, input logic v,
                                  input logic signed [15:0] s, input logic signed [7:0] c);
        exp_t item;
        rst_n        = r;
        bus.en       = e;
        bus.in_valid = v;
        bus.sample   = s;
        bus.coef     = c;
        @(posedge clk);
        if (!r) begin
            sb.delete();
            exp_valid = 1'b0;
            exp_prod  = '0;
            exp_ovf   = 1'b0;
        end else if (e) begin
            en_edges++;
            if (v) begin
                item.due = en_edges + LAT - 1;
                ref_mult(s, c, item.prod, item.ovf);
                sb.push_back(item);
            end
            if (sb.size() > 0 && sb[0].due == en_edges) begin
                item      = sb.pop_front();
                exp_valid = 1'b1;
                exp_prod  = item.prod;
                exp_ovf   = item.ovf;
            end else begin
                exp_valid = 1'b0;
                exp_ovf   = 1'b0;
            end
        end
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 16'sd0, 8'sd0);
    endtask

    initial begin
        logic signed [15:0] s;
        logic signed [7:0]  c;
        logic               v;
        logic               e;

        apply_stimulus(1'b0, 1'b1, 1'b0, 16'sd0, 8'sd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'sd5, 8'sd5);

        $display("[TB] single item latency");
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'sd1000, 8'sd64);
        idle(11);

        $display("[TB] directed sign and saturation cases");
        apply_stimulus(1'b1, 1'b1, 1'b1, -16'sd1000,  8'sd64);
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'sd1000,  -8'sd128);
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'sd0,     -8'sd77);
        apply_stimulus(1'b1, 1'b1, 1'b1, -16'sd32768, -8'sd128);
        apply_stimulus(1'b1, 1'b1, 1'b1, -16'sd32768, 8'sd127);
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'sd3,      8'sd32);
        apply_stimulus(1'b1, 1'b1, 1'b1, -16'sd3,     8'sd32);
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'sd32767,  -8'sd128);
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'sd32767,  8'sd127);
        idle(12);

        $display("[TB] back-to-back stream with stall");
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin
                for (int k = 0; k < 3; k++)
                    apply_stimulus(1'b1, 1'b0, 1'b1, 16'($urandom), 8'($urandom));
            end
            apply_stimulus(1'b1, 1'b1, 1'b1, 16'(100 * i), 8'sd64);
        end
        idle(12);

        $display("[TB] reset with items in flight");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 16'(1234 + i), 8'sd100);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'sd0, 8'sd0);
        idle(12);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            s = 16'($urandom);
            c = 8'($urandom);
            if ($urandom_range(0, 9) == 0) s = -16'sd32768;
            if ($urandom_range(0, 9) == 0) c = -8'sd128;
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 6) != 0);
            apply_stimulus(1'b1, e, v, s, c);
        end
        idle(12);

        check_one("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
